hazard_ctrl: RTL and testbench

Pipeline sequencing controller for the 5-stage MIPS core. It works alongside the EX/MEM/WB forwarding logic.
- Detects load-use hazards that forwarding cannot cover.
- Sequences the multi-cycle multiply/divide unit (start, busy count, HI/LO write) and stalls dependent instructions.
- Drives PC/IF_ID write enables, ID_EX bubble insertion and IF_ID flush on taken branches.
- Keeps a saturating stall-cycle counter for performance debug.

---
 rtl/hazard_ctrl_pkg.sv | 18 +
 rtl/hazard_ctrl_md_sequencer.sv | 90 +++++++++
 rtl/hazard_ctrl.sv | 85 ++++++++
 tb/tb_hazard_ctrl.sv | 139 +++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
// rtl/hazard_ctrl_pkg.sv - shared types and constants for the pipeline hazard controller
//
// Package pipe_pkg:
//   REG_W      - register specifier width
//   ZERO_REG   - hard-wired zero register ($zero), never a real dependency
//   md_state_t - mul/div sequencer state encoding (MD_IDLE, MD_BUSY, MD_DONE)
package pipe_pkg;

  localparam int REG_W = 5;
  localparam logic [REG_W-1:0] ZERO_REG = 5'd0;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_BUSY = 2'd1,
    MD_DONE = 2'd2
  } md_state_t;

endpackage

// File: rtl/hazard_ctrl_md_sequencer.sv
// rtl/hazard_ctrl_md_sequencer.sv - multi-cycle multiply/divide unit sequencer
//
// Ports:
//   clk        in   core clock
//   rst        in   synchronous active-high reset
//   launch_req in   a mul/div instruction in ID wants to issue and is not stalled
//   state      out  current sequencer state (used by the hazard equations)
//   md_start   out  one-cycle launch pulse
//   md_busy    out  operation in flight
//   md_done    out  one-cycle pulse, HI/LO written at the end of this cycle
module md_sequencer
  import pipe_pkg::*;
#(
  parameter int MD_LATENCY = 4
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      launch_req,
  output md_state_t state,
  output logic      md_start,
  output logic      md_busy,
  output logic      md_done
);

  // Loading LATENCY-2 accounts for the launch cycle and the DONE cycle, so
  // md_done lands exactly MD_LATENCY cycles after md_start.
  localparam logic [3:0] CNT_LOAD = 4'(MD_LATENCY - 2);

  md_state_t  state_n;
  logic [3:0] md_cnt;
  logic [3:0] md_cnt_n;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= MD_IDLE;
      md_cnt <= 4'd0;
    end else begin
      state  <= state_n;
      md_cnt <= md_cnt_n;
    end
  end

  // Next-state logic
  always_comb begin
    state_n  = state;
    md_cnt_n = md_cnt;
    case (state)
      MD_IDLE: begin
        if (md_start) begin
          state_n  = MD_BUSY;
          md_cnt_n = CNT_LOAD;
        end
      end
      MD_BUSY: begin
        if (md_cnt == 4'd0) begin
          state_n = MD_DONE;
        end else begin
          md_cnt_n = md_cnt - 4'd1;
        end
      end
      MD_DONE: begin
        // A dependent mul/div waiting in ID issues in the DONE cycle.
        if (md_start) begin
          state_n  = MD_BUSY;
          md_cnt_n = CNT_LOAD;
        end else begin
          state_n = MD_IDLE;
        end
      end
      default: begin
        state_n  = MD_IDLE;
        md_cnt_n = 4'd0;
      end
    endcase
  end

  // Output logic; reset suppresses every pulse so an abandoned op never completes.
  always_comb begin
    md_start = 1'b0;
    md_busy  = 1'b0;
    md_done  = 1'b0;
    if (!rst) begin
      md_start = launch_req & ((state == MD_IDLE) | (state == MD_DONE));
      md_busy  = (state == MD_BUSY);
      md_done  = (state == MD_DONE);
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline hazard/stall controller for the 5-stage MIPS core
//
// Ports:
//   clk, rst        core clock, synchronous active-high reset
//   id_rs, id_rt    source fields of the instruction in IF_ID
//   id_is_md        ID instruction is mult/multu/div/divu
//   id_uses_hilo    ID instruction is mfhi/mflo/mthi/mtlo
//   id_ex_memread   instruction in ID_EX is a load
//   id_ex_rt        destination of that load
//   branch_taken    branch/jump resolved taken in ID
//   pc_write        PC enable
//   if_id_write     IF_ID enable
//   id_ex_bubble    zero ID_EX control fields
//   if_id_flush     clear IF_ID
//   md_start/busy/done  mul/div sequencing
//   stall_count     saturating stalled-cycle counter
module hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int MD_LATENCY = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_is_md,
  input  logic             id_uses_hilo,
  input  logic             id_ex_memread,
  input  logic [REG_W-1:0] id_ex_rt,
  input  logic             branch_taken,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             id_ex_bubble,
  output logic             if_id_flush,
  output logic             md_start,
  output logic             md_busy,
  output logic             md_done,
  output logic [CNT_W-1:0] stall_count
);

  md_state_t md_state;
  logic      load_use;
  logic      md_stall;
  logic      stall;

  // Forwarding cannot cover a load result needed in the very next cycle;
  // a load to $zero produces nothing to wait for.
  assign load_use = id_ex_memread & (id_ex_rt != ZERO_REG) &
                    ((id_ex_rt == id_rs) | (id_ex_rt == id_rt));

  // While BUSY both a new mul/div and any HI/LO access must wait; in DONE a
  // new mul/div may issue but HI/LO is only written at the end of the cycle.
  assign md_stall = ((md_state == MD_BUSY) & (id_is_md | id_uses_hilo)) |
                    ((md_state == MD_DONE) & id_uses_hilo);

  assign stall = load_use | md_stall;

  assign pc_write     = ~rst & ~stall;
  assign if_id_write  = ~rst & ~stall;
  assign id_ex_bubble = rst | stall;
  // A stalled branch re-resolves later, so it must not flush early.
  assign if_id_flush  = ~rst & branch_taken & ~stall;

  md_sequencer #(
    .MD_LATENCY (MD_LATENCY)
  ) u_md_sequencer (
    .clk        (clk),
    .rst        (rst),
    .launch_req (id_is_md & ~stall),
    .state      (md_state),
    .md_start   (md_start),
    .md_busy    (md_busy),
    .md_done    (md_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_count <= '0;
    end else if (stall && (stall_count != {CNT_W{1'b1}})) begin
      stall_count <= stall_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - scoreboard testbench for hazard_ctrl
module tb_hazard_ctrl;

  localparam int CNT_W = 4;

  typedef struct {
    string      name;
    logic [6:0] ctl;   // {pc_write, if_id_write, id_ex_bubble, if_id_flush, md_start, md_busy, md_done}
    int         cnt;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic [4:0]       id_rs, id_rt, id_ex_rt;
  logic             id_is_md, id_uses_hilo, id_ex_memread, branch_taken;
  logic             pc_write, if_id_write, id_ex_bubble, if_id_flush;
  logic             md_start, md_busy, md_done;
  logic [CNT_W-1:0] stall_count;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   stim_done = 1'b0;

  always #5 clk = ~clk;

  hazard_ctrl #(.MD_LATENCY(4), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .id_rs         (id_rs),
    .id_rt         (id_rt),
    .id_is_md      (id_is_md),
    .id_uses_hilo  (id_uses_hilo),
    .id_ex_memread (id_ex_memread),
    .id_ex_rt      (id_ex_rt),
    .branch_taken  (branch_taken),
    .pc_write      (pc_write),
    .if_id_write   (if_id_write),
    .id_ex_bubble  (id_ex_bubble),
    .if_id_flush   (if_id_flush),
    .md_start      (md_start),
    .md_busy       (md_busy),
    .md_done       (md_done),
    .stall_count   (stall_count)
  );

  // Control-vector shorthands
  localparam logic [6:0] RUN   = 7'b1100000;
  localparam logic [6:0] STALL = 7'b0010000;
  localparam logic [6:0] RSTV  = 7'b0010000;

  task automatic step(input string name, input logic r,
                      input logic [4:0] rs, input logic [4:0] rt,
                      input logic md, input logic hl, input logic mr,
                      input logic [4:0] ert, input logic br,
                      input logic [6:0] ectl, input int ecnt);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; id_rs = rs; id_rt = rt; id_is_md = md; id_uses_hilo = hl;
    id_ex_memread = mr; id_ex_rt = ert; branch_taken = br;
    e.name = name; e.ctl = ectl; e.cnt = ecnt;
    exp_q.push_back(e);
  endtask

  // Monitor: outputs are valid every cycle; sample mid-cycle and compare.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      logic [6:0] got;
      e = exp_q.pop_front();
      got = {pc_write, if_id_write, id_ex_bubble, if_id_flush, md_start, md_busy, md_done};
      checks++;
      if (got !== e.ctl || int'(stall_count) != e.cnt) begin
        errors++;
        $display("FAIL %s: got ctl=%b cnt=%0d, expected ctl=%b cnt=%0d",
                 e.name, got, stall_count, e.ctl, e.cnt);
      end
    end
  end

  initial begin
    rst = 1'b1; id_rs = 0; id_rt = 0; id_is_md = 0; id_uses_hilo = 0;
    id_ex_memread = 0; id_ex_rt = 0; branch_taken = 0;
    repeat (2) @(posedge clk);

    //    name          rst rs  rt md hl mr ert br  ctl                cnt
    step("reset",        1, 0,  0, 1, 1, 0, 0, 1, RSTV,              0);
    step("post_reset",   0, 0,  0, 0, 0, 0, 0, 0, RUN,               0);
    step("load_use_rs",  0, 8,  0, 0, 0, 1, 8, 0, STALL,             0);
    step("after_lu",     0, 0,  0, 0, 0, 0, 0, 0, RUN,               1);
    step("lu_zero_reg",  0, 0,  0, 0, 0, 1, 0, 0, RUN,               1);
    step("load_use_rt",  0, 3,  9, 0, 0, 1, 9, 0, STALL,             1);
    // Single mul/div with a dependent mflo
    step("md_launch",    0, 0,  0, 1, 0, 0, 0, 0, RUN | 7'b0000100, 2);
    step("hilo_busy1",   0, 0,  0, 0, 1, 0, 0, 0, STALL | 7'b0000010, 2);
    step("hilo_busy2",   0, 0,  0, 0, 1, 0, 0, 0, STALL | 7'b0000010, 3);
    step("hilo_busy3",   0, 0,  0, 0, 1, 0, 0, 0, STALL | 7'b0000010, 4);
    step("hilo_done",    0, 0,  0, 0, 1, 0, 0, 0, STALL | 7'b0000001, 5);
    step("hilo_release", 0, 0,  0, 0, 1, 0, 0, 0, RUN,               6);
    // Back-to-back mul/div
    step("b2b_first",    0, 0,  0, 1, 0, 0, 0, 0, RUN | 7'b0000100, 6);
    step("b2b_wait1",    0, 0,  0, 1, 0, 0, 0, 0, STALL | 7'b0000010, 6);
    step("b2b_wait2",    0, 0,  0, 1, 0, 0, 0, 0, STALL | 7'b0000010, 7);
    step("b2b_wait3",    0, 0,  0, 1, 0, 0, 0, 0, STALL | 7'b0000010, 8);
    step("b2b_second",   0, 0,  0, 1, 0, 0, 0, 0, RUN | 7'b0000101, 9);
    step("b2b_busy1",    0, 0,  0, 0, 0, 0, 0, 0, RUN | 7'b0000010, 9);
    step("b2b_busy2",    0, 0,  0, 0, 0, 0, 0, 0, RUN | 7'b0000010, 9);
    step("b2b_busy3",    0, 0,  0, 0, 0, 0, 0, 0, RUN | 7'b0000010, 9);
    step("b2b_done",     0, 0,  0, 0, 0, 0, 0, 0, RUN | 7'b0000001, 9);
    step("b2b_idle",     0, 0,  0, 0, 0, 0, 0, 0, RUN,               9);
    // Branch against a load-use stall
    step("br_stalled",   0, 5,  0, 0, 0, 1, 5, 1, STALL,             9);
    step("br_flush",     0, 0,  0, 0, 0, 0, 0, 1, RUN | 7'b0001000, 10);
    // Saturation of the 4-bit counter
    for (int i = 0; i < 7; i++)
      step("saturate",   0, 7,  0, 0, 0, 1, 7, 0, STALL, (10 + i > 15) ? 15 : 10 + i);
    // Load-use blocks a mul/div launch, which issues next cycle
    step("lu_blocks_md", 0, 0,  4, 1, 0, 1, 4, 0, STALL,             15);
    step("md_after_lu",  0, 0,  0, 1, 0, 0, 0, 0, RUN | 7'b0000100, 15);
    step("mid_busy",     0, 0,  0, 0, 0, 0, 0, 0, RUN | 7'b0000010, 15);
    // Reset mid-operation abandons the op
    step("rst_mid",      1, 0,  0, 0, 0, 0, 0, 0, RSTV,              15);
    step("post_rst1",    0, 0,  0, 0, 0, 0, 0, 0, RUN,               0);
    step("post_rst2",    0, 0,  0, 0, 0, 0, 0, 0, RUN,               0);
    step("post_rst3",    0, 0,  0, 0, 0, 0, 0, 0, RUN,               0);

    repeat (2) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
    end
    stim_done = 1'b1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
